// File: rtl/oflow_conflict_resolve.sv
// Score-board conflict resolver: scans pairs of occupied rows for duplicate selected IDs,
// flips each loser to its second candidate and flags rows whose second candidate still conflicts.
module oflow_conflict_resolve #(
    parameter int MAX_ROWS   = 16,
    parameter int ROW_LEN    = $clog2(MAX_ROWS),
    parameter int ID_LEN     = 12,
    parameter int SCORE_LEN  = 16,
    parameter int MAX_PASSES = 4
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 start_cr,
    input  logic [ROW_LEN:0]     num_rows,
    input  logic                 ready_new_frame,
    input  logic [SCORE_LEN-1:0] score_to_cr,
    input  logic [ID_LEN-1:0]    id_to_cr,
    output logic [ROW_LEN-1:0]   row_sel_from_cr,
    output logic                 write_to_pointer,
    output logic [ROW_LEN-1:0]   row_to_change,
    output logic                 data_from_cr,
    output logic                 done_cr,
    output logic                 unresolved,
    output logic [MAX_ROWS-1:0]  new_obj_flag
);

    localparam int CNT_W  = ROW_LEN + 1;
    localparam int PASS_W = $clog2(MAX_PASSES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_I   = 3'd1;
    localparam logic [2:0] S_COMPARE  = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_END_PASS = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{ROW_LEN{1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(MAX_PASSES);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     i_q, i_d, j_q, j_d, n_q, n_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic                 dirty_q, dirty_d;
    logic [ID_LEN-1:0]    id_i_q, id_i_d;
    logic [SCORE_LEN-1:0] score_i_q, score_i_d;
    logic [MAX_ROWS-1:0]  shadow_q, shadow_d, flag_q, flag_d;
    logic                 unres_q, unres_d;
    logic [ROW_LEN-1:0]   loser_q, loser_d, row_chg_q, row_chg_d;
    logic                 loser_i_q, loser_i_d;
    logic                 wr_q, wr_d, done_q, done_d;

    logic [CNT_W-1:0]     i_inc_s, j_inc_s, adv_i_s, adv_j_s;
    logic [2:0]           adv_state_s;
    logic                 conflict_s, loser_is_i_s;
    logic [ROW_LEN-1:0]   loser_s;

    assign i_inc_s      = i_q + CNT_ONE;
    assign j_inc_s      = j_q + CNT_ONE;
    assign conflict_s   = (id_to_cr == id_i_q) && (id_i_q != {ID_LEN{1'b0}});
    // A tie on score loses to the higher row index (row j).
    assign loser_is_i_s = (score_to_cr < score_i_q);
    assign loser_s      = loser_is_i_s ? i_q[ROW_LEN-1:0] : j_q[ROW_LEN-1:0];

    assign row_sel_from_cr  = (state_q == S_LOAD_I) ? i_q[ROW_LEN-1:0] : j_q[ROW_LEN-1:0];
    assign write_to_pointer = wr_q;
    assign data_from_cr     = wr_q;
    assign row_to_change    = row_chg_q;
    assign done_cr          = done_q;
    assign unresolved       = unres_q;
    assign new_obj_flag     = flag_q;

    // Step to the next pair after a compare: next j, else next i, else end of pass.
    always_comb begin
        adv_state_s = S_END_PASS;
        adv_i_s     = i_q;
        adv_j_s     = j_q;
        if (j_inc_s < n_q) begin
            adv_state_s = S_COMPARE;
            adv_j_s     = j_inc_s;
        end else if (i_inc_s < n_q) begin
            adv_state_s = S_LOAD_I;
            adv_i_s     = i_inc_s;
        end else begin
            adv_state_s = S_END_PASS;
        end
    end

    // Next-state and datapath updates for the scan FSM.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        n_d       = n_q;
        pass_d    = pass_q;
        dirty_d   = dirty_q;
        id_i_d    = id_i_q;
        score_i_d = score_i_q;
        shadow_d  = shadow_q;
        flag_d    = flag_q;
        unres_d   = unres_q;
        loser_d   = loser_q;
        loser_i_d = loser_i_q;
        if (ready_new_frame) begin
            state_d   = S_IDLE;
            i_d       = '0;
            j_d       = '0;
            n_d       = '0;
            pass_d    = '0;
            dirty_d   = 1'b0;
            id_i_d    = '0;
            score_i_d = '0;
            shadow_d  = '0;
            flag_d    = '0;
            unres_d   = 1'b0;
            loser_d   = '0;
            loser_i_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_cr) begin
                        n_d      = num_rows;
                        i_d      = '0;
                        pass_d   = '0;
                        dirty_d  = 1'b0;
                        shadow_d = '0;
                        flag_d   = '0;
                        unres_d  = 1'b0;
                        state_d  = (num_rows == '0) ? S_DONE : S_LOAD_I;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD_I: begin
                    id_i_d    = id_to_cr;
                    score_i_d = score_to_cr;
                    j_d       = i_inc_s;
                    // j = i+1, so the "next i" case collapses into end of pass.
                    state_d   = (i_inc_s < n_q) ? S_COMPARE : S_END_PASS;
                end
                S_COMPARE: begin
                    if (conflict_s && !shadow_q[loser_s]) begin
                        loser_d   = loser_s;
                        loser_i_d = loser_is_i_s;
                        state_d   = S_WRITE;
                    end else begin
                        if (conflict_s) begin
                            flag_d[loser_s] = 1'b1;
                        end else begin
                            flag_d = flag_q;
                        end
                        state_d = adv_state_s;
                        i_d     = adv_i_s;
                        j_d     = adv_j_s;
                    end
                end
                S_WRITE: begin
                    shadow_d[loser_q] = 1'b1;
                    dirty_d           = 1'b1;
                    if (loser_i_q) begin
                        state_d = S_LOAD_I;
                    end else begin
                        state_d = adv_state_s;
                        i_d     = adv_i_s;
                        j_d     = adv_j_s;
                    end
                end
                S_END_PASS: begin
                    if (dirty_q && ((pass_q + PASS_ONE) < PASS_MAX)) begin
                        pass_d  = pass_q + PASS_ONE;
                        dirty_d = 1'b0;
                        i_d     = '0;
                        state_d = S_LOAD_I;
                    end else if (dirty_q) begin
                        unres_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        wr_d      = (state_d == S_WRITE);
        row_chg_d = wr_d ? loser_d : {ROW_LEN{1'b0}};
        done_d    = (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            pass_q    <= '0;
            dirty_q   <= 1'b0;
            id_i_q    <= '0;
            score_i_q <= '0;
            shadow_q  <= '0;
            flag_q    <= '0;
            unres_q   <= 1'b0;
            loser_q   <= '0;
            loser_i_q <= 1'b0;
            wr_q      <= 1'b0;
            row_chg_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            n_q       <= n_d;
            pass_q    <= pass_d;
            dirty_q   <= dirty_d;
            id_i_q    <= id_i_d;
            score_i_q <= score_i_d;
            shadow_q  <= shadow_d;
            flag_q    <= flag_d;
            unres_q   <= unres_d;
            loser_q   <= loser_d;
            loser_i_q <= loser_i_d;
            wr_q      <= wr_d;
            row_chg_q <= row_chg_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_oflow_conflict_resolve.sv
// Directed bench for oflow_conflict_resolve with a two-candidate score-board model.
module tb_oflow_conflict_resolve;

    logic        clk = 1'b0;
    logic        reset_N, start_cr, ready_new_frame;
    logic [4:0]  num_rows;
    logic [15:0] score_to_cr;
    logic [11:0] id_to_cr;
    logic [3:0]  row_sel_from_cr, row_to_change;
    logic        write_to_pointer, data_from_cr, done_cr, unresolved;
    logic [15:0] new_obj_flag;

    always #5 clk = ~clk;

    oflow_conflict_resolve dut (
        .clk(clk), .reset_N(reset_N), .start_cr(start_cr), .num_rows(num_rows),
        .ready_new_frame(ready_new_frame), .score_to_cr(score_to_cr), .id_to_cr(id_to_cr),
        .row_sel_from_cr(row_sel_from_cr), .write_to_pointer(write_to_pointer),
        .row_to_change(row_to_change), .data_from_cr(data_from_cr), .done_cr(done_cr),
        .unresolved(unresolved), .new_obj_flag(new_obj_flag)
    );

    // Score-board model: per-row best and second candidate, pointer selects which is visible.
    logic [11:0] id1 [16];
    logic [11:0] id2 [16];
    logic [15:0] sc1 [16];
    logic [15:0] sc2 [16];
    logic [15:0] ptr;
    logic        clr_ptr;

    assign id_to_cr    = ptr[row_sel_from_cr] ? id2[row_sel_from_cr] : id1[row_sel_from_cr];
    assign score_to_cr = ptr[row_sel_from_cr] ? sc2[row_sel_from_cr] : sc1[row_sel_from_cr];

    always @(posedge clk) begin
        if (clr_ptr) ptr <= 16'h0;
        else if (write_to_pointer) ptr[row_to_change] <= data_from_cr;
    end

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0;
    int wr_rows [8];
    int cyc;
    int dcount;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (write_to_pointer === 1'b1) begin
            check_eq("wr_data", 32'(data_from_cr), 32'd1);
            if (wr_cnt < 8) wr_rows[wr_cnt] = 32'(row_to_change);
            wr_cnt++;
        end
    end

    task automatic clear_board();
        for (int r = 0; r < 16; r++) begin
            id1[r] = 12'd0; id2[r] = 12'd0; sc1[r] = 16'd0; sc2[r] = 16'd0;
        end
        clr_ptr = 1'b1;
        @(negedge clk);
        clr_ptr = 1'b0;
    endtask

    task automatic set_row(input int r, input int a, input int sa, input int b, input int sb);
        id1[r] = 12'(a); sc1[r] = 16'(sa); id2[r] = 12'(b); sc2[r] = 16'(sb);
    endtask

    task automatic start_frame(input int n);
        wr_cnt = 0;
        @(negedge clk);
        num_rows = 5'(n);
        start_cr = 1'b1;
        @(negedge clk);
        start_cr = 1'b0;
    endtask

    // Cycle 1 is the period right after the edge that samples start_cr.
    task automatic run_frame(input int n, output int c);
        start_frame(n);
        c = 1;
        while (done_cr !== 1'b1 && c < 600) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_seen", 32'(done_cr), 32'd1);
        @(negedge clk);
        check_eq("done_pulse", 32'(done_cr), 32'd0);
    endtask

    initial begin
        clr_ptr = 1'b1; reset_N = 1'b0; start_cr = 1'b0; num_rows = 5'd0; ready_new_frame = 1'b0;
        for (int r = 0; r < 16; r++) begin
            id1[r] = 12'd0; id2[r] = 12'd0; sc1[r] = 16'd0; sc2[r] = 16'd0;
        end
        #12;
        check_eq("rst_out", {write_to_pointer, data_from_cr, done_cr, unresolved, row_to_change, row_sel_from_cr},
                 32'd0);
        check_eq("rst_flag", 32'(new_obj_flag), 32'd0);
        @(negedge clk);
        reset_N = 1'b1;

        // No conflict
        clear_board();
        set_row(0, 5, 1, 50, 1); set_row(1, 7, 1, 70, 1); set_row(2, 9, 1, 90, 1); set_row(3, 11, 1, 110, 1);
        run_frame(4, cyc);
        check_eq("t1_cyc", 32'(cyc), 32'd12);
        check_eq("t1_wr", 32'(wr_cnt), 32'd0);
        check_eq("t1_flag", 32'(new_obj_flag), 32'd0);
        check_eq("t1_unres", 32'(unresolved), 32'd0);

        // Single conflict, loser j
        clear_board();
        set_row(0, 5, 10, 50, 1); set_row(1, 7, 15, 70, 1); set_row(2, 5, 20, 8, 1);
        run_frame(3, cyc);
        check_eq("t2_cyc", 32'(cyc), 32'd16);
        check_eq("t2_wr", 32'(wr_cnt), 32'd1);
        check_eq("t2_row", 32'(wr_rows[0]), 32'd2);
        check_eq("t2_unres", 32'(unresolved), 32'd0);
        check_eq("t2_flag", 32'(new_obj_flag), 32'd0);

        // Loser is row i, re-latch and rescan from j=2
        clear_board();
        set_row(0, 2, 1, 40, 1); set_row(1, 6, 30, 20, 1); set_row(2, 9, 1, 90, 1); set_row(3, 6, 5, 60, 1);
        run_frame(4, cyc);
        check_eq("t3_cyc", 32'(cyc), 32'd27);
        check_eq("t3_wr", 32'(wr_cnt), 32'd1);
        check_eq("t3_row", 32'(wr_rows[0]), 32'd1);

        // Tie goes against the higher index
        clear_board();
        set_row(0, 3, 7, 30, 1); set_row(1, 3, 7, 4, 1);
        run_frame(2, cyc);
        check_eq("t4_cyc", 32'(cyc), 32'd10);
        check_eq("t4_wr", 32'(wr_cnt), 32'd1);
        check_eq("t4_row", 32'(wr_rows[0]), 32'd1);

        // Second candidate still conflicts
        clear_board();
        set_row(0, 5, 10, 50, 1); set_row(1, 5, 20, 5, 20);
        run_frame(2, cyc);
        check_eq("t5_cyc", 32'(cyc), 32'd10);
        check_eq("t5_wr", 32'(wr_cnt), 32'd1);
        check_eq("t5_row", 32'(wr_rows[0]), 32'd1);
        check_eq("t5_flag", 32'(new_obj_flag), 32'h0002);
        @(negedge clk); @(negedge clk);
        check_eq("t5_hold", 32'(new_obj_flag), 32'h0002);
        ready_new_frame = 1'b1;
        @(negedge clk);
        ready_new_frame = 1'b0;
        check_eq("t5_rnf_clr", 32'(new_obj_flag), 32'd0);

        // Chain of conflicts exhausting all passes
        clear_board();
        set_row(0, 1, 50, 9, 1); set_row(1, 2, 40, 1, 1); set_row(2, 3, 30, 2, 1);
        set_row(3, 4, 10, 99, 1); set_row(4, 4, 20, 3, 1);
        run_frame(5, cyc);
        check_eq("t6_wr", 32'(wr_cnt), 32'd4);
        check_eq("t6_rows", {8'(wr_rows[0]), 8'(wr_rows[1]), 8'(wr_rows[2]), 8'(wr_rows[3])}, 32'h04020100);
        check_eq("t6_unres", 32'(unresolved), 32'd1);
        check_eq("t6_flag", 32'(new_obj_flag), 32'd0);

        // N=0 and N=1 latency
        clear_board();
        run_frame(0, cyc);
        check_eq("n0_cyc", 32'(cyc), 32'd1);
        check_eq("n0_unres_clr", 32'(unresolved), 32'd0);
        set_row(0, 5, 1, 50, 1);
        run_frame(1, cyc);
        check_eq("n1_cyc", 32'(cyc), 32'd3);
        check_eq("n1_wr", 32'(wr_cnt), 32'd0);

        // ready_new_frame mid-COMPARE
        clear_board();
        set_row(0, 5, 1, 50, 1); set_row(1, 7, 1, 70, 1); set_row(2, 9, 1, 90, 1); set_row(3, 11, 1, 110, 1);
        start_frame(4);
        @(negedge clk);
        check_eq("ab_sel_mid", 32'(row_sel_from_cr), 32'd1);
        ready_new_frame = 1'b1;
        @(negedge clk);
        ready_new_frame = 1'b0;
        check_eq("ab_sel_clr", 32'(row_sel_from_cr), 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_cr === 1'b1) dcount++;
        end
        check_eq("ab_no_done", 32'(dcount), 32'd0);

        // Asynchronous reset during a pointer write
        clear_board();
        set_row(0, 2, 1, 40, 1); set_row(1, 6, 30, 20, 1); set_row(2, 9, 1, 90, 1); set_row(3, 6, 5, 60, 1);
        start_frame(4);
        cyc = 1;
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rs_wr_pre", 32'(write_to_pointer), 32'd1);
        #1 reset_N = 1'b0;
        #1;
        check_eq("rs_out", {write_to_pointer, data_from_cr, done_cr, unresolved, row_to_change, row_sel_from_cr},
                 32'd0);
        @(negedge clk);
        reset_N = 1'b1;

        // Normal operation after reset
        clear_board();
        set_row(0, 3, 7, 30, 1); set_row(1, 3, 7, 4, 1);
        run_frame(2, cyc);
        check_eq("post_cyc", 32'(cyc), 32'd10);
        check_eq("post_wr", 32'(wr_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
